// File: rtl/lcd_text_driver_pkg.sv
// lcd_pkg: shared types, command bytes and helper functions for the
// HD44780 text driver (lcd_text_driver, lcd_xfer).
package lcd_pkg;

  // Top-level sequencing states.
  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_ADDR1,
    S_LINE1,
    S_ADDR2,
    S_LINE2,
    S_DONE
  } state_e;

  // Phases of one bus transfer inside lcd_xfer.
  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_PULSE,
    X_WAIT
  } xfer_phase_e;

  localparam logic [7:0] LCD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_LINE2   = 8'hC0;

  // Shared width of the power-up counter and the transfer timing counter.
  localparam int TIMER_W = 20;

  // Control bytes 0x00-0x1F show as blanks; everything else passes through.
  function automatic logic [7:0] map_char(input logic [7:0] b);
    return (b < 8'h20) ? 8'h20 : b;
  endfunction

  // Init command list, in the order the controller needs them.
  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return LCD_FUNCSET;
      2'd1:    return LCD_DISPON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

  // Character c of a 256-bit buffer sits at bits [255-8c -: 8];
  // 255-8c equals {~c, 3'b111} for a 5-bit c.
  function automatic logic [7:0] buf_char(input logic [255:0] b, input logic [4:0] c);
    return map_char(b[{~c, 3'b111} -: 8]);
  endfunction

endpackage

// File: rtl/lcd_text_driver_if.sv
// lcd_text_driver_if: write-only 8-bit parallel HD44780 bus.
//   lcd_rs   : 0 = command, 1 = data
//   lcd_rw   : always 0 (write-only)
//   lcd_e    : enable strobe, data latched by the LCD on its falling edge
//   lcd_data : 8-bit data bus
// master = the driver, slave = the display (or a monitor).
interface lcd_text_driver_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_e, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_e, input  lcd_data);
endinterface

// File: rtl/lcd_text_driver_xfer.sv
// lcd_xfer: one LCD bus transfer = 1 setup cycle + EnPulseCycles with
// lcd_e high + a wait (CmdWaitCycles, or ClearWaitCycles when long_wait).
// lcd_rs/lcd_data are registered at start and held until the next start.
// Ports:
//   start, rs, data, long_wait : transfer request and its contents
//   done                       : one-cycle pulse in the last wait cycle
//   lcd_e, lcd_rs, lcd_data    : registered bus outputs
//   phase_dbg                  : current transfer phase
// Handshake: start is accepted when the block is idle or in its done cycle
// (so back-to-back transfers need no gap); a start at any other time is
// ignored. The setup cycle is the cycle after the accepting edge.
module lcd_xfer
  import lcd_pkg::*;
#(
  parameter int EnPulseCycles   = 12,
  parameter int CmdWaitCycles   = 2500,
  parameter int ClearWaitCycles = 80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rs,
  input  logic [7:0]  data,
  input  logic        long_wait,
  output logic        done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output xfer_phase_e phase_dbg
);

  localparam logic [TIMER_W-1:0] EN_LAST  = TIMER_W'(EnPulseCycles - 1);
  localparam logic [TIMER_W-1:0] CMD_LAST = TIMER_W'(CmdWaitCycles - 1);
  localparam logic [TIMER_W-1:0] CLR_LAST = TIMER_W'(ClearWaitCycles - 1);

  xfer_phase_e        phase_q, phase_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] wait_last;
  logic               rs_q, rs_d;
  logic               long_q, long_d;
  logic               e_q, e_d;
  logic [7:0]         data_q, data_d;

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    rs_d      = rs_q;
    data_d    = data_q;
    long_d    = long_q;
    done      = 1'b0;
    wait_last = long_q ? CLR_LAST : CMD_LAST;

    case (phase_q)
      X_SETUP: begin
        phase_d = X_PULSE;
        cnt_d   = '0;
      end
      X_PULSE: begin
        if (cnt_q == EN_LAST) begin
          phase_d = X_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end
      X_WAIT: begin
        if (cnt_q == wait_last) begin
          done    = 1'b1;
          phase_d = X_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end
      default: ;
    endcase

    if (start && ((phase_q == X_IDLE) || done)) begin
      phase_d = X_SETUP;
      cnt_d   = '0;
      rs_d    = rs;
      data_d  = data;
      long_d  = long_wait;
    end

    // Registered strobe so lcd_e is glitch-free and drops on async reset.
    e_d = (phase_d == X_PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= X_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
      e_q     <= e_d;
    end
  end

  assign lcd_e     = e_q;
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign phase_dbg = phase_q;

endmodule

// File: rtl/lcd_text_driver.sv
// lcd_text_driver: runs the HD44780 init sequence after reset, then
// repeatedly writes both 16-char lines from a per-frame snapshot of
// DisplayBuffer (char c = DisplayBuffer[255-8c -: 8]).
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   DisplayBuffer   : 32 chars x 8 bits
//   RefreshEn       : start another frame (sampled in S_IDLE only)
//   lcd             : LCD bus (master side)
//   InitDone        : set after the clear command completes, reset-only clear
//   FrameDone       : one-cycle pulse after the last char of a frame
//   state_dbg       : sequencer state
//   xfer_phase_dbg  : transfer phase
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int DisplayBufferSize = 256,
  parameter int PowerUpCycles     = 750000,
  parameter int EnPulseCycles     = 12,
  parameter int CmdWaitCycles     = 2500,
  parameter int ClearWaitCycles   = 80000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DisplayBufferSize-1:0] DisplayBuffer,
  input  logic                         RefreshEn,
  lcd_text_driver_if.master            lcd,
  output logic                         InitDone,
  output logic                         FrameDone,
  output state_e                       state_dbg,
  output xfer_phase_e                  xfer_phase_dbg
);

  localparam logic [TIMER_W-1:0] PU_LAST = TIMER_W'(PowerUpCycles - 1);

  state_e                       state_q, state_d;
  logic [TIMER_W-1:0]           pu_q, pu_d;
  logic [1:0]                   ci_q, ci_d;
  logic [4:0]                   idx_q, idx_d;
  logic [DisplayBufferSize-1:0] snap_q, snap_d;
  logic                         init_done_q, init_done_d;
  logic                         frame_done_q, frame_done_d;

  logic       x_start, x_rs, x_long, x_done;
  logic [7:0] x_data;
  logic [4:0] next_idx;
  logic [7:0] next_cmd;

  lcd_xfer #(
    .EnPulseCycles  (EnPulseCycles),
    .CmdWaitCycles  (CmdWaitCycles),
    .ClearWaitCycles(ClearWaitCycles)
  ) u_xfer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (x_start),
    .rs       (x_rs),
    .data     (x_data),
    .long_wait(x_long),
    .done     (x_done),
    .lcd_e    (lcd.lcd_e),
    .lcd_rs   (lcd.lcd_rs),
    .lcd_data (lcd.lcd_data),
    .phase_dbg(xfer_phase_dbg)
  );

  // Each transfer is started in the cycle the previous one reports done,
  // so transfers run back-to-back with no idle cycle between them.
  always_comb begin
    state_d      = state_q;
    pu_d         = pu_q;
    ci_d         = ci_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    init_done_d  = init_done_q;
    x_start      = 1'b0;
    x_rs         = 1'b0;
    x_data       = 8'h00;
    x_long       = 1'b0;
    next_idx     = idx_q + 5'd1;
    next_cmd     = init_cmd(ci_q + 2'd1);

    case (state_q)
      S_POWERUP: begin
        if (pu_q == PU_LAST) begin
          x_start = 1'b1;
          x_data  = LCD_FUNCSET;
          ci_d    = 2'd0;
          state_d = S_INIT;
        end else begin
          pu_d = pu_q + TIMER_W'(1);
        end
      end
      S_INIT: begin
        if (x_done) begin
          if (ci_q == 2'd3) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            ci_d    = ci_q + 2'd1;
            x_start = 1'b1;
            x_data  = next_cmd;
            x_long  = (next_cmd == LCD_CLEAR);
          end
        end
      end
      S_IDLE: begin
        if (RefreshEn) begin
          snap_d  = DisplayBuffer;
          x_start = 1'b1;
          x_data  = LCD_LINE1;
          state_d = S_ADDR1;
        end
      end
      S_ADDR1: begin
        if (x_done) begin
          x_start = 1'b1;
          x_rs    = 1'b1;
          x_data  = buf_char(snap_q, idx_q);
          state_d = S_LINE1;
        end
      end
      S_LINE1: begin
        if (x_done) begin
          idx_d   = next_idx;
          x_start = 1'b1;
          if (idx_q == 5'd15) begin
            x_data  = LCD_LINE2;
            state_d = S_ADDR2;
          end else begin
            x_rs   = 1'b1;
            x_data = buf_char(snap_q, next_idx);
          end
        end
      end
      S_ADDR2: begin
        if (x_done) begin
          x_start = 1'b1;
          x_rs    = 1'b1;
          x_data  = buf_char(snap_q, idx_q);
          state_d = S_LINE2;
        end
      end
      S_LINE2: begin
        if (x_done) begin
          // idx wraps 31 -> 0 here, ready for the next frame.
          idx_d = next_idx;
          if (idx_q == 5'd31) begin
            state_d = S_DONE;
          end else begin
            x_start = 1'b1;
            x_rs    = 1'b1;
            x_data  = buf_char(snap_q, next_idx);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_POWERUP;
    endcase

    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_POWERUP;
      pu_q         <= '0;
      ci_q         <= 2'd0;
      idx_q        <= 5'd0;
      snap_q       <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pu_q         <= pu_d;
      ci_q         <= ci_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd.lcd_rw = 1'b0;
  assign InitDone   = init_done_q;
  assign FrameDone  = frame_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver with short timing parameters. A transfer-level
// model (queue of {rs,data} transfers plus timing arithmetic) predicts the
// bus and status outputs every cycle; bytes latched on lcd_e falls are also
// checked against hand-written literals.
module tb_lcd_text_driver;
  import lcd_pkg::*;

  localparam int PU  = 10;
  localparam int EN  = 2;
  localparam int CW  = 3;
  localparam int CLW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] disp_buf;
  logic         refresh_en;
  logic         init_done, frame_done;
  state_e       state_dbg;
  xfer_phase_e  xfer_phase_dbg;

  lcd_text_driver_if lcd_bus ();

  lcd_text_driver #(
    .DisplayBufferSize(256),
    .PowerUpCycles    (PU),
    .EnPulseCycles    (EN),
    .CmdWaitCycles    (CW),
    .ClearWaitCycles  (CLW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .DisplayBuffer (disp_buf),
    .RefreshEn     (refresh_en),
    .lcd           (lcd_bus),
    .InitDone      (init_done),
    .FrameDone     (frame_done),
    .state_dbg     (state_dbg),
    .xfer_phase_dbg(xfer_phase_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cycle 0 is the first cycle after rst_n rises. Transfers are taken from
  // m_q; each lasts 1 + EN + wait cycles with lcd_e high at offsets 1..EN.
  int         m_n, m_off, m_len;
  logic       m_busy, m_go, m_frame, m_init;
  logic       m_rs;
  logic [7:0] m_data;
  logic [8:0] m_q[$];

  function automatic logic [7:0] ref_char(input logic [255:0] b, input int c);
    logic [7:0] v;
    v = b[255 - 8*c -: 8];
    return (v < 8'h20) ? 8'h20 : v;
  endfunction

  task automatic start_xfer();
    logic [8:0] t;
    t      = m_q.pop_front();
    m_rs   = t[8];
    m_data = t[7:0];
    m_len  = 1 + EN + ((!t[8] && t[7:0] == 8'h01) ? CLW : CW);
    m_off  = 0;
    m_busy = 1'b1;
  endtask

  always @(negedge clk) begin : model_cmp
    logic exp_fd, idle_now, exp_e;
    logic [12:0] act_v, exp_v;
    if (!rst_n) begin
      m_n = -1; m_off = 0; m_len = 0;
      m_busy = 1'b0; m_go = 1'b0; m_frame = 1'b0; m_init = 1'b0;
      m_rs = 1'b0; m_data = 8'h00;
      m_q.delete();
    end else begin
      m_n++;
      exp_fd   = 1'b0;
      idle_now = 1'b0;
      if (m_go) begin
        m_go = 1'b0;
        start_xfer();
      end else if (m_busy) begin
        m_off++;
        if (m_off == m_len) begin
          m_busy = 1'b0;
          if (m_q.size() > 0) start_xfer();
          else if (m_frame) begin
            exp_fd  = 1'b1;
            m_frame = 1'b0;
          end else begin
            m_init   = 1'b1;
            idle_now = 1'b1;
          end
        end
      end else if (!m_init && m_n == PU) begin
        m_q = '{9'h038, 9'h00C, 9'h006, 9'h001};
        start_xfer();
      end else if (m_init) begin
        idle_now = 1'b1;
      end

      // Idle cycle with refresh: snapshot now, first setup next cycle.
      if (idle_now && refresh_en) begin
        m_q.push_back(9'h080);
        for (int c = 0; c < 16; c++) m_q.push_back({1'b1, ref_char(disp_buf, c)});
        m_q.push_back(9'h0C0);
        for (int c = 16; c < 32; c++) m_q.push_back({1'b1, ref_char(disp_buf, c)});
        m_frame = 1'b1;
        m_go    = 1'b1;
      end

      exp_e = m_busy && (m_off >= 1) && (m_off <= EN);
      act_v = {lcd_bus.lcd_e, lcd_bus.lcd_rs, lcd_bus.lcd_rw, lcd_bus.lcd_data, init_done, frame_done};
      exp_v = {exp_e, m_rs, 1'b0, m_data, m_init, exp_fd};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle %0d {e,rs,rw,data,init,fd}: got %b_%b_%b_%h_%b_%b expected %b_%b_%b_%h_%b_%b",
                 m_n, act_v[12], act_v[11], act_v[10], act_v[9:2], act_v[1], act_v[0],
                 exp_v[12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- bus monitor ----------------
  logic [8:0] cap_q[$];
  int         cap_cyc, first_rise, init_cyc, rise_cnt;
  logic       prev_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_cyc = -1; first_rise = -1; init_cyc = -1; prev_e = 1'b0;
    end else begin
      cap_cyc++;
      if (lcd_bus.lcd_e && !prev_e) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = cap_cyc;
      end
      if (!lcd_bus.lcd_e && prev_e) cap_q.push_back({lcd_bus.lcd_rs, lcd_bus.lcd_data});
      if (init_done && init_cyc < 0) init_cyc = cap_cyc;
      prev_e = lcd_bus.lcd_e;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_fd(input int budget, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < budget);
    check(nm, {31'd0, frame_done}, 32'd1);
  endtask

  function automatic logic [31:0] cap_at(input int i);
    return (i < cap_q.size()) ? {23'd0, cap_q[i]} : 32'hFFFF_FFFF;
  endfunction

  // ---------------- stimulus ----------------
  initial begin : stim
    string      s;
    int         r0, n41;
    logic [8:0] init_exp[4];
    init_exp   = '{9'h038, 9'h00C, 9'h006, 9'h001};
    rise_cnt   = 0;
    refresh_en = 1'b0;
    disp_buf   = '0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lcd_e",  {31'd0, lcd_bus.lcd_e},  32'd0);
    check("rst_lcd_rs", {31'd0, lcd_bus.lcd_rs}, 32'd0);
    check("rst_lcd_rw", {31'd0, lcd_bus.lcd_rw}, 32'd0);
    check("rst_lcd_data", {24'd0, lcd_bus.lcd_data}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Init with refresh disabled.
    repeat (150) @(posedge clk);
    #1;
    check("init_cap_count", cap_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("init_cmd%0d", i), cap_at(i), {23'd0, init_exp[i]});
    check("first_e_rise_cycle", first_rise, 11);
    check("init_done_cycle", init_cyc, 39);
    check("init_rises", rise_cnt, 4);

    // Frame 1 from "0123456789abcdef" + zeros; buffer changes mid-frame.
    s = "0123456789abcdef";
    disp_buf = '0;
    for (int i = 0; i < 16; i++) disp_buf[255 - 8*i -: 8] = s[i];
    cap_q.delete();
    refresh_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    disp_buf = {32{8'h41}};
    wait_fd(400, "fd_frame1");
    check("f1_count", cap_q.size(), 34);
    check("f1_addr1", cap_at(0), 32'h080);
    for (int i = 0; i < 16; i++) check($sformatf("f1_char%0d", i), cap_at(1 + i), {23'd0, 1'b1, s[i]});
    check("f1_addr2", cap_at(17), 32'h0C0);
    for (int i = 18; i < 34; i++) check($sformatf("f1_blank%0d", i - 18), cap_at(i), 32'h120);

    // Frame 2 picks up the 0x41 buffer.
    cap_q.delete();
    wait_fd(400, "fd_frame2");
    n41 = 0;
    foreach (cap_q[i]) if (cap_q[i] == 9'h141) n41++;
    check("f2_count", cap_q.size(), 34);
    check("f2_addr1", cap_at(0), 32'h080);
    check("f2_addr2", cap_at(17), 32'h0C0);
    check("f2_n41", n41, 32);

    // Drop RefreshEn during char 5 of line 1 of frame 3.
    cap_q.delete();
    repeat (40) @(posedge clk);
    #1;
    refresh_en = 1'b0;
    wait_fd(400, "fd_frame3");
    check("f3_count", cap_q.size(), 34);
    r0 = rise_cnt;
    repeat (100) @(negedge clk);
    check("idle_rises", rise_cnt - r0, 0);

    // Reset while lcd_e is high during char 20.
    @(posedge clk);
    #1;
    refresh_en = 1'b1;
    repeat (135) @(negedge clk);
    check("e_high_char20", {31'd0, lcd_bus.lcd_e}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_e", {31'd0, lcd_bus.lcd_e}, 32'd0);
    check("async_rst_init_done", {31'd0, init_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cap_q.delete();
    repeat (60) @(posedge clk);
    #1;
    check("reinit_cmd0", cap_at(0), 32'h038);
    check("reinit_first_rise", first_rise, 11);

    // Random buffer contents and RefreshEn toggling.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 59) == 0) refresh_en = ~refresh_en;
      if ($urandom_range(0, 24) == 0) begin
        for (int w = 0; w < 8; w++) disp_buf[32*w +: 32] = $urandom;
        for (int i = 0; i < 32; i++)
          if ($urandom_range(0, 3) == 0) disp_buf[8*i +: 8] = 8'($urandom_range(0, 31));
      end
    end
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
